// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_sb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file access bundle: read ports, writeback, issue and flush.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rsaddr;
    logic [NRD*XLEN-1:0] rso;
    logic [NRD-1:0]      rsbusy;
    logic                regwr;
    logic [AW-1:0]       rdaddr;
    logic [XLEN-1:0]     win;
    logic                issue;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic                ready;

    modport master (
        output rsaddr, regwr, rdaddr, win, issue, issue_rd, flush,
        input  rso, rsbusy, ready
    );

    modport slave (
        input  rsaddr, regwr, rdaddr, win, issue, issue_rd, flush,
        output rso, rsbusy, ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set on issue, cleared on writeback, flushed in bulk.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        issue,
    input  logic [$clog2(NREGS)-1:0]    issue_rd,
    input  logic                        regwr,
    input  logic [$clog2(NREGS)-1:0]    rdaddr,
    input  logic                        flush,
    input  logic [NRD*$clog2(NREGS)-1:0] rsaddr,
    output logic [NRD-1:0]              rsbusy
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy;

    // Issue is applied after the writeback clear so it wins on a shared target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            if (flush) begin
                busy <= '0;
            end else begin
                if (regwr)
                    busy[rdaddr] <= 1'b0;
                if (issue && issue_rd != '0)
                    busy[issue_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        rsbusy = '0;
        for (int unsigned i = 0; i < NRD; i++)
            rsbusy[i] = busy[rsaddr[i*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with init sweep, optional write-through bypass and busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_sb_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            ready_q;
    logic [XLEN-1:0] regs [NREGS];
    logic [NRD-1:0]  sb_busy;
    logic            run;
    logic            wr_ok;

    assign run   = (state == RUN);
    assign wr_ok = run && bus.regwr && (bus.rdaddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (!run)
            regs[cnt] <= '0;
        else if (wr_ok)
            regs[bus.rdaddr] <= bus.win;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .issue    (bus.issue),
        .issue_rd (bus.issue_rd),
        .regwr    (bus.regwr),
        .rdaddr   (bus.rdaddr),
        .flush    (bus.flush),
        .rsaddr   (bus.rsaddr),
        .rsbusy   (sb_busy)
    );

    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        bus.rso    = '0;
        bus.rsbusy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            a   = bus.rsaddr[i*AW +: AW];
            hit = (BYPASS != 0) && wr_ok && (bus.rdaddr == a);
            if (run) begin
                if (hit)
                    bus.rso[i*XLEN +: XLEN] = bus.win;
                else if (a != '0)
                    bus.rso[i*XLEN +: XLEN] = regs[a];
                bus.rsbusy[i] = sb_busy[i] && !hit;
            end
        end
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb with and without bypass, driven in lockstep.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_nb ();

    assign bus_nb.rsaddr   = bus.rsaddr;
    assign bus_nb.regwr    = bus.regwr;
    assign bus_nb.rdaddr   = bus.rdaddr;
    assign bus_nb.win      = bus.win;
    assign bus_nb.issue    = bus.issue;
    assign bus_nb.issue_rd = bus.issue_rd;
    assign bus_nb.flush    = bus.flush;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_nb)
    );

    typedef struct {
        logic        regwr;
        logic [4:0]  rdaddr;
        logic [31:0] win;
        logic        issue;
        logic [4:0]  issue_rd;
        logic        flush;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] enb0;
        logic [1:0]  enbb;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(logic wr, logic [4:0] rd, logic [31:0] d, logic is, logic [4:0] ird,
                                logic fl, logic [4:0] r0, logic [4:0] r1, logic [31:0] e0,
                                logic [31:0] e1, logic [1:0] eb, logic [31:0] enb0, logic [1:0] enbb);
        vec_t v;
        v.regwr = wr; v.rdaddr = rd; v.win = d; v.issue = is; v.issue_rd = ird; v.flush = fl;
        v.rs0 = r0; v.rs1 = r1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.enb0 = enb0; v.enbb = enbb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.regwr = 1'b0; bus.rdaddr = '0; bus.win = '0;
        bus.issue = 1'b0; bus.issue_rd = '0; bus.flush = 1'b0;
    endtask

    task automatic count_sweep(input string nm);
        int unsigned n;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            n = k;
            if (bus.ready) break;
        end
        idle();
        chk({nm, "_edges"}, n, 32'd31);
        chk({nm, "_ready_nb"}, {31'd0, bus_nb.ready}, 32'd1);
    endtask

    initial begin
        idle();
        bus.rsaddr = '0;
        step();
        step();
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_rso", bus.rso[31:0], 32'd0);
        chk("rst_busy", {30'd0, bus.rsbusy}, 32'd0);

        // Operations offered during the sweep must be ignored.
        bus.regwr = 1'b1; bus.rdaddr = 5'd31; bus.win = 32'hAAAA5555;
        bus.issue = 1'b1; bus.issue_rd = 5'd31; bus.flush = 1'b0;
        bus.rsaddr = {5'd31, 5'd31};
        rst = 1'b0;
        #1;
        chk("init_rso", bus.rso[31:0], 32'd0);
        chk("init_busy", {30'd0, bus.rsbusy}, 32'd0);
        count_sweep("sweep1");

        vt[0]  = mk(0, 0, 0,            0, 0,  0, 5,  31, 0,            0,            2'b00, 0,            2'b00);
        vt[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0,  0, 3,  3,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0,            2'b00);
        vt[2]  = mk(0, 0, 0,            0, 0,  0, 3,  0,  32'hDEADBEEF, 0,            2'b00, 32'hDEADBEEF, 2'b00);
        vt[3]  = mk(0, 0, 0,            1, 7,  0, 7,  7,  0,            0,            2'b00, 0,            2'b00);
        vt[4]  = mk(0, 0, 0,            0, 0,  0, 7,  7,  0,            0,            2'b11, 0,            2'b11);
        vt[5]  = mk(1, 7, 32'h12345678, 0, 0,  0, 7,  7,  32'h12345678, 32'h12345678, 2'b00, 0,            2'b11);
        vt[6]  = mk(0, 0, 0,            0, 0,  0, 7,  7,  32'h12345678, 32'h12345678, 2'b00, 32'h12345678, 2'b00);
        vt[7]  = mk(1, 9, 32'h99,       1, 9,  0, 9,  3,  32'h99,       32'hDEADBEEF, 2'b00, 0,            2'b00);
        vt[8]  = mk(0, 0, 0,            0, 0,  0, 9,  9,  32'h99,       32'h99,       2'b11, 32'h99,       2'b11);
        vt[9]  = mk(0, 0, 0,            1, 4,  1, 4,  9,  0,            32'h99,       2'b10, 0,            2'b10);
        vt[10] = mk(0, 0, 0,            0, 0,  0, 4,  9,  0,            32'h99,       2'b00, 0,            2'b00);
        vt[11] = mk(1, 0, 32'hFFFFFFFF, 1, 0,  0, 0,  0,  0,            0,            2'b00, 0,            2'b00);
        vt[12] = mk(0, 0, 0,            0, 0,  0, 0,  0,  0,            0,            2'b00, 0,            2'b00);
        vt[13] = mk(0, 0, 0,            0, 0,  1, 3,  7,  32'hDEADBEEF, 32'h12345678, 2'b00, 32'hDEADBEEF, 2'b00);
        vt[14] = mk(1, 31, 32'hA5A5A5A5, 0, 0, 0, 31, 30, 32'hA5A5A5A5, 0,            2'b00, 0,            2'b00);
        vt[15] = mk(0, 0, 0,            0, 0,  0, 30, 31, 0,            32'hA5A5A5A5, 2'b00, 0,            2'b00);

        for (int i = 0; i < 16; i++) begin
            bus.regwr = vt[i].regwr; bus.rdaddr = vt[i].rdaddr; bus.win = vt[i].win;
            bus.issue = vt[i].issue; bus.issue_rd = vt[i].issue_rd; bus.flush = vt[i].flush;
            bus.rsaddr = {vt[i].rs1, vt[i].rs0};
            #1;
            chk($sformatf("v%0d_rso0", i), bus.rso[31:0], vt[i].e0);
            chk($sformatf("v%0d_rso1", i), bus.rso[63:32], vt[i].e1);
            chk($sformatf("v%0d_busy", i), {30'd0, bus.rsbusy}, {30'd0, vt[i].eb});
            chk($sformatf("v%0d_nb_rso0", i), bus_nb.rso[31:0], vt[i].enb0);
            chk($sformatf("v%0d_nb_busy", i), {30'd0, bus_nb.rsbusy}, {30'd0, vt[i].enbb});
            step();
        end
        idle();

        // Mark x20 busy, then reset: busy must clear, sweep must restart.
        bus.issue = 1'b1; bus.issue_rd = 5'd20;
        step();
        idle();
        bus.rsaddr = {5'd3, 5'd20};
        #1;
        chk("x20_busy", {30'd0, bus.rsbusy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_ready", {31'd0, bus.ready}, 32'd0);
        chk("async_busy", {30'd0, bus.rsbusy}, 32'd0);
        chk("async_rso", bus.rso[63:32], 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("mid_sweep_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_sweep("sweep2");
        #1;
        chk("post_x3", bus.rso[63:32], 32'd0);
        chk("post_x20_busy", {30'd0, bus.rsbusy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: register count, power of two, at least 4; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 Parameter BYPASS, default 1: 1 enables write-through forwarding to the read ports; 0 disables it.
REQ-005 Port clk, input, 1 bit: the block's single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port rsaddr, input, NRD*AW bits: read addresses; port i occupies bits [i*AW +: AW].
REQ-008 Port rso, output, NRD*XLEN bits: read data; port i occupies bits [i*XLEN +: XLEN].
REQ-009 Port rsbusy, output, NRD bits: scoreboard busy bit of the register addressed by each read port.
REQ-010 Port regwr, input, 1 bit: writeback enable.
REQ-011 Port rdaddr, input, AW bits: writeback destination register.
REQ-012 Port win, input, XLEN bits: writeback data.
REQ-013 Port issue, input, 1 bit: an instruction with a destination register has issued.
REQ-014 Port issue_rd, input, AW bits: destination register of the issuing instruction.
REQ-015 Port flush, input, 1 bit: clear all scoreboard busy bits.
REQ-016 Port ready, output, 1 bit: initialisation sweep is complete; the block accepts operations.

Function
REQ-017 The FSM SHALL have two states, INIT and RUN, and SHALL enter INIT on reset.
REQ-018 In INIT, a counter SHALL start at 1 and clear one register to zero per clock edge, in order 1 to NREGS-1.
REQ-019 The edge that clears register NREGS-1 SHALL move the FSM to RUN; ready SHALL be 1 from that edge onward, exactly NREGS-1 edges after reset release.
REQ-020 In INIT, regwr, issue and flush SHALL be ignored, rso SHALL be all zeros and rsbusy SHALL be all zeros.
REQ-021 Register 0 SHALL always read as 0; writebacks to it and issues to it SHALL be ignored.
REQ-022 In RUN, reads SHALL be combinational: rso port i = register[rsaddr port i].
REQ-023 In RUN, regwr=1 with rdaddr!=0 SHALL write win into register rdaddr at the clock edge.
REQ-024 When BYPASS=1, RUN, regwr=1, rdaddr!=0 and rdaddr equals rsaddr port i, rso port i SHALL equal win in the same cycle.
REQ-025 When BYPASS=1 under the same conditions, rsbusy port i SHALL be 0 in that cycle.
REQ-026 The scoreboard SHALL hold one busy bit per register; issue=1 SHALL set busy[issue_rd] at the edge.
REQ-027 A writeback (regwr=1) SHALL clear busy[rdaddr] at the edge.
REQ-028 If issue and a writeback target the same register in the same cycle, busy SHALL end set (issue wins).
REQ-029 flush=1 SHALL clear every busy bit at the edge and SHALL override a simultaneous issue.
REQ-030 Register data SHALL be unaffected by flush.
REQ-031 rsbusy port i SHALL equal busy[rsaddr port i], subject to REQ-025; busy[0] SHALL always be 0.
REQ-032 Multiple read ports addressing the same register SHALL all return identical data and busy values.

Reset
REQ-033 rst SHALL asynchronously force state INIT, counter to 1, all busy bits to 0 and ready to 0.
REQ-034 Assertion of rst mid-sweep or in RUN SHALL restart the full sweep.
REQ-035 Register contents SHALL not be reset directly; they become zero only through the sweep.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (INIT, RUN) and the default values of XLEN and NREGS.
REQ-037 The scoreboard SHALL be a sub-module regfile_scoreboard, parameters NREGS and NRD, covering REQ-026 to REQ-029 and REQ-031.

Verification
REQ-038 Reset, then hold idle: ready=0 for 31 edges and 1 after the 31st; then reading x5 and x31 both return 0.
REQ-039 Write x3=0xDEADBEEF with port 0 reading x3: rso port 0 = 0xDEADBEEF in the same cycle with BYPASS=1, and from the next cycle with BYPASS=0.
REQ-040 Issue x7, then read x7 on both ports: rsbusy=2'b11; after a writeback to x7, rsbusy=2'b00.
REQ-041 Issue x9 and write back x9 in the same cycle: busy[x9]=1 afterwards.
REQ-042 Issue x4 and flush in the same cycle: busy[x4]=0 afterwards.
REQ-043 Write x0=0xFFFFFFFF and issue x0: x0 reads 0 and is not busy. Assert rst at sweep count 10: ready stays 0 for 31 further edges.
